// File: rtl/spwm_pkg.sv
// Shared constants for the SPWM timer: mode encodings and default parameters.
package spwm_pkg;

  // Counting modes
  localparam logic MODE_EDGE   = 1'b0;  // up-count 0..top, wrap to 0
  localparam logic MODE_CENTER = 1'b1;  // up to top, down to 0, repeat

  // Default sizing
  localparam int unsigned WIDTH_DEF    = 14;
  localparam int unsigned CHANNELS_DEF = 3;
  localparam int unsigned CNT_MAX_DEF  = 9999;

endpackage

// File: rtl/spwm_compare.sv
// One PWM channel: registers (cnt < duty) each enabled cycle.
// Ports:
//   clock, reset  - clock, async active-low reset
//   clr           - synchronous clear of the output
//   en            - update enable; output holds when low
//   cnt, duty     - current count and shadow compare value
//   pwm           - registered PWM output
module spwm_compare #(
  parameter int unsigned WIDTH = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm
);

  logic pwm_d;

  // Next output value; duty==0 never compares true, duty>top always does
  always_comb begin
    pwm_d = pwm;
    if (clr) begin
      pwm_d = 1'b0;
    end else if (en) begin
      pwm_d = (cnt < duty);
    end
  end

  // Output register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm <= 1'b0;
    end else begin
      pwm <= pwm_d;
    end
  end

endmodule

// File: rtl/spwm_timer.sv
// Shadow-buffered PWM timer with edge- and center-aligned counting.
// Ports:
//   clock, reset  - clock, async active-low reset
//   rst_syn       - synchronous clear, force-loads shadows from inputs
//   e             - count enable
//   mode          - 0 edge-aligned, 1 center-aligned
//   period, duty  - requested top and per-channel compare values
//   load          - request shadow update at the next period boundary
//   load_ack      - one-cycle pulse after a shadow update
//   cnt, dir      - current count and direction (1 = down)
//   carry         - combinational period-boundary event
//   pwm_out       - registered PWM outputs
module spwm_timer
  import spwm_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned CHANNELS = CHANNELS_DEF,
  parameter int unsigned CNT_MAX  = CNT_MAX_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rst_syn,
  input  logic                      e,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      load,
  output logic                      load_ack,
  output logic [WIDTH-1:0]          cnt,
  output logic                      dir,
  output logic                      carry,
  output logic [CHANNELS-1:0]       pwm_out
);

  localparam int unsigned DW = CHANNELS * WIDTH;

  // Shadow registers
  logic             mode_sh;
  logic [WIDTH-1:0] top_sh;
  logic [DW-1:0]    duty_sh;
  logic             pending;

  // Next-state values
  logic             mode_d;
  logic [WIDTH-1:0] top_d;
  logic [DW-1:0]    duty_d;
  logic             pending_d;
  logic [WIDTH-1:0] cnt_d;
  logic             dir_d;
  logic             load_ack_d;

  logic at_top;
  logic at_bottom;
  logic turn;
  logic upd;

  // Period boundary detection; a zero top makes every enabled cycle a boundary
  always_comb begin
    at_top    = (cnt == top_sh);
    at_bottom = (cnt == '0);
    if (top_sh == '0) begin
      turn = 1'b1;
    end else if (mode_sh == MODE_EDGE) begin
      turn = at_top;
    end else begin
      turn = at_bottom && dir;
    end
    carry = reset && !rst_syn && e && turn;
    upd   = carry && (pending || load);
  end

  // Next-state logic; in a boundary cycle the wrap uses the freshly loaded shadows
  always_comb begin
    mode_d     = mode_sh;
    top_d      = top_sh;
    duty_d     = duty_sh;
    pending_d  = pending || load;
    cnt_d      = cnt;
    dir_d      = dir;
    load_ack_d = 1'b0;

    if (rst_syn) begin
      mode_d    = mode;
      top_d     = period;
      duty_d    = duty;
      pending_d = 1'b0;
      cnt_d     = '0;
      dir_d     = 1'b0;
    end else begin
      if (upd) begin
        mode_d     = mode;
        top_d      = period;
        duty_d     = duty;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end

      if (carry) begin
        // Center mode restarts upward from 1 unless the new top is 0
        dir_d = 1'b0;
        if ((mode_d == MODE_CENTER) && (top_d != '0)) begin
          cnt_d = WIDTH'(1);
        end else begin
          cnt_d = '0;
        end
      end else if (e) begin
        if (mode_sh == MODE_EDGE) begin
          cnt_d = cnt + WIDTH'(1);
        end else if (!dir) begin
          if (at_top) begin
            dir_d = 1'b1;
            cnt_d = cnt - WIDTH'(1);
          end else begin
            cnt_d = cnt + WIDTH'(1);
          end
        end else begin
          cnt_d = cnt - WIDTH'(1);
        end
      end
    end
  end

  // State and shadow registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_sh  <= MODE_EDGE;
      top_sh   <= WIDTH'(CNT_MAX);
      duty_sh  <= '0;
      pending  <= 1'b0;
      cnt      <= '0;
      dir      <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      mode_sh  <= mode_d;
      top_sh   <= top_d;
      duty_sh  <= duty_d;
      pending  <= pending_d;
      cnt      <= cnt_d;
      dir      <= dir_d;
      load_ack <= load_ack_d;
    end
  end

  // Per-channel compare outputs
  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    spwm_compare #(
      .WIDTH(WIDTH)
    ) u_cmp (
      .clock(clock),
      .reset(reset),
      .clr  (rst_syn),
      .en   (e),
      .cnt  (cnt),
      .duty (duty_sh[g*WIDTH +: WIDTH]),
      .pwm  (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_spwm_timer.sv
// Directed self-checking bench for spwm_timer (default parameters).
module tb_spwm_timer;

  localparam int W = 14;

  logic          clock;
  logic          reset;
  logic          rst_syn;
  logic          e;
  logic          mode;
  logic [W-1:0]  period;
  logic [3*W-1:0] duty;
  logic          load;
  logic          load_ack;
  logic [W-1:0]  cnt;
  logic          dir;
  logic          carry;
  logic [2:0]    pwm_out;

  int total = 0;
  int bad   = 0;

  spwm_timer dut (
    .clock   (clock),
    .reset   (reset),
    .rst_syn (rst_syn),
    .e       (e),
    .mode    (mode),
    .period  (period),
    .duty    (duty),
    .load    (load),
    .load_ack(load_ack),
    .cnt     (cnt),
    .dir     (dir),
    .carry   (carry),
    .pwm_out (pwm_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Force-load shadows through rst_syn; leaves cnt=0, pwm=0, nothing pending
  task automatic set_cfg(input logic m, input int p, input int d0, input int d1, input int d2);
    mode    = m;
    period  = W'(p);
    duty    = {W'(d2), W'(d1), W'(d0)};
    load    = 1'b0;
    e       = 1'b0;
    rst_syn = 1'b1;
    cyc();
    rst_syn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; rst_syn = 1'b0; e = 1'b1; mode = 1'b0;
    period = '0; duty = '0; load = 1'b0;
    cyc();
    total++; if (cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
    total++; if (dir !== 1'b0) begin bad++; $display("FAIL reset_dir got=%0b want=0", dir); end
    total++; if (pwm_out !== 3'b000) begin bad++; $display("FAIL reset_pwm got=%b want=000", pwm_out); end
    total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0b want=0", load_ack); end
    total++; if (carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%0b want=0", carry); end
    #4 reset = 1'b1;
    e = 1'b0;
    cyc();
  endtask

  task automatic test_edge();
    int ec;
    logic ep;
    set_cfg(1'b0, 4, 2, 0, 0);
    e = 1'b1;
    for (int k = 0; k < 11; k++) begin
      ec = k % 5;
      ep = (k == 0) ? 1'b0 : (((k - 1) % 5) < 2);
      total++; if (cnt !== W'(ec)) begin bad++; $display("FAIL edge_cnt k=%0d got=%0d want=%0d", k, cnt, ec); end
      total++; if (carry !== (ec == 4)) begin bad++; $display("FAIL edge_carry k=%0d got=%0b want=%0b", k, carry, ec == 4); end
      total++; if (pwm_out[0] !== ep) begin bad++; $display("FAIL edge_pwm k=%0d got=%0b want=%0b", k, pwm_out[0], ep); end
      cyc();
    end
  endtask

  task automatic test_center();
    int ec[14] = '{0,1,2,3,2,1,0,1,2,3,2,1,0,1};
    int ed[14] = '{0,0,0,0,1,1,1,0,0,0,1,1,1,0};
    logic ep;
    set_cfg(1'b1, 3, 2, 0, 0);
    e = 1'b1;
    for (int k = 0; k < 14; k++) begin
      ep = (k == 0) ? 1'b0 : (ec[k-1] < 2);
      total++; if (cnt !== W'(ec[k])) begin bad++; $display("FAIL ctr_cnt k=%0d got=%0d want=%0d", k, cnt, ec[k]); end
      total++; if (dir !== 1'(ed[k])) begin bad++; $display("FAIL ctr_dir k=%0d got=%0b want=%0d", k, dir, ed[k]); end
      total++; if (carry !== (k == 6 || k == 12)) begin bad++; $display("FAIL ctr_carry k=%0d got=%0b want=%0b", k, carry, k == 6 || k == 12); end
      total++; if (pwm_out[0] !== ep) begin bad++; $display("FAIL ctr_pwm k=%0d got=%0b want=%0b", k, pwm_out[0], ep); end
      cyc();
    end
  endtask

  task automatic test_load();
    logic ep[12] = '{0,1,0,0,0,0,1,1,1,0,0,1};
    logic seen;
    set_cfg(1'b0, 4, 1, 0, 0);
    e = 1'b1;
    for (int k = 0; k < 12; k++) begin
      load = (k == 2 || k == 3);
      if (k == 2) duty = {W'(0), W'(0), W'(3)};
      #1;
      total++; if (pwm_out[0] !== ep[k]) begin bad++; $display("FAIL load_pwm k=%0d got=%0b want=%0b", k, pwm_out[0], ep[k]); end
      total++; if (load_ack !== (k == 5)) begin bad++; $display("FAIL load_ack k=%0d got=%0b want=%0b", k, load_ack, k == 5); end
      cyc();
    end
    load = 1'b0;
    // load raised in the carry cycle itself takes effect immediately
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (carry) seen = 1'b1; else cyc();
    end
    total++; if (!seen) begin bad++; $display("FAIL load_wait_carry got=0 want=1"); end
    duty = '0;
    load = 1'b1;
    cyc();
    load = 1'b0;
    total++; if (load_ack !== 1'b1) begin bad++; $display("FAIL load_same_cycle_ack got=%0b want=1", load_ack); end
    cyc();
    total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL load_ack_pulse got=%0b want=0", load_ack); end
    total++; if (pwm_out[0] !== 1'b0) begin bad++; $display("FAIL load_new_duty0 got=%0b want=0", pwm_out[0]); end
  endtask

  task automatic test_bounds();
    logic pat[6] = '{1,0,1,1,0,1};
    set_cfg(1'b0, 3, 0, 4, 2);
    e = 1'b1;
    for (int k = 1; k < 9; k++) begin
      cyc();
      total++; if (pwm_out[1:0] !== 2'b10) begin bad++; $display("FAIL bound_pwm k=%0d got=%b want=10", k, pwm_out[1:0]); end
    end
    for (int m = 0; m < 2; m++) begin
      set_cfg(1'(m), 0, 1, 0, 0);
      for (int k = 0; k < 6; k++) begin
        e = pat[k];
        #1;
        total++; if (carry !== pat[k]) begin bad++; $display("FAIL zero_carry m=%0d k=%0d got=%0b want=%0b", m, k, carry, pat[k]); end
        total++; if (cnt !== '0) begin bad++; $display("FAIL zero_cnt m=%0d k=%0d got=%0d want=0", m, k, cnt); end
        cyc();
      end
    end
    // center mode reloaded with top 0 must wrap to 0, not 1
    set_cfg(1'b1, 2, 0, 0, 0);
    e = 1'b1; mode = 1'b1; period = '0; load = 1'b1;
    cyc(); load = 1'b0;
    cyc(); cyc(); cyc();
    total++; if (carry !== 1'b1 || cnt !== '0) begin bad++; $display("FAIL ctr_zero_turn carry=%0b cnt=%0d want carry=1 cnt=0", carry, cnt); end
    cyc();
    total++; if (cnt !== '0) begin bad++; $display("FAIL ctr_zero_wrap got=%0d want=0", cnt); end
    total++; if (load_ack !== 1'b1) begin bad++; $display("FAIL ctr_zero_ack got=%0b want=1", load_ack); end
  endtask

  task automatic test_enable();
    int ec[7] = '{0,1,1,2,2,3,3};
    logic ep[7] = '{0,1,1,1,1,0,0};
    set_cfg(1'b0, 9, 2, 0, 0);
    for (int k = 0; k < 7; k++) begin
      e = (k % 2 == 0);
      #1;
      total++; if (cnt !== W'(ec[k])) begin bad++; $display("FAIL en_cnt k=%0d got=%0d want=%0d", k, cnt, ec[k]); end
      total++; if (pwm_out[0] !== ep[k]) begin bad++; $display("FAIL en_pwm k=%0d got=%0b want=%0b", k, pwm_out[0], ep[k]); end
      cyc();
    end
  endtask

  task automatic test_syn_load();
    logic ep;
    set_cfg(1'b0, 9, 9, 0, 0);
    e = 1'b1;
    cyc(); cyc(); cyc();
    rst_syn = 1'b1; load = 1'b1; period = W'(5); duty = {W'(0), W'(0), W'(3)};
    cyc();
    rst_syn = 1'b0; load = 1'b0;
    for (int k = 0; k < 7; k++) begin
      ep = (k == 0) ? 1'b0 : ((k - 1) < 3);
      total++; if (cnt !== W'(k % 6)) begin bad++; $display("FAIL syn_cnt k=%0d got=%0d want=%0d", k, cnt, k % 6); end
      total++; if (carry !== (k == 5)) begin bad++; $display("FAIL syn_carry k=%0d got=%0b want=%0b", k, carry, k == 5); end
      total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL syn_ack k=%0d got=%0b want=0", k, load_ack); end
      total++; if (pwm_out[0] !== ep) begin bad++; $display("FAIL syn_pwm k=%0d got=%0b want=%0b", k, pwm_out[0], ep); end
      cyc();
    end
  endtask

  task automatic test_async_reset();
    int ncarry;
    set_cfg(1'b0, 3, 4, 0, 0);
    e = 1'b1;
    cyc(); cyc(); cyc();
    load = 1'b1;
    cyc();
    load = 1'b0;
    total++; if (load_ack !== 1'b1 || pwm_out[0] !== 1'b1) begin bad++; $display("FAIL pre_reset ack=%0b pwm=%0b want 1 1", load_ack, pwm_out[0]); end
    cyc();
    #2 reset = 1'b0;
    #1;
    total++; if (cnt !== '0 || dir !== 1'b0) begin bad++; $display("FAIL async_cnt cnt=%0d dir=%0b want 0 0", cnt, dir); end
    total++; if (pwm_out !== 3'b000) begin bad++; $display("FAIL async_pwm got=%b want=000", pwm_out); end
    total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL async_ack got=%0b want=0", load_ack); end
    total++; if (carry !== 1'b0) begin bad++; $display("FAIL async_carry got=%0b want=0", carry); end
    #1 reset = 1'b1;
    ncarry = 0;
    for (int k = 0; k < 9999; k++) begin
      cyc();
      if (carry && k < 9998) ncarry++;
    end
    total++; if (ncarry !== 0) begin bad++; $display("FAIL default_early_carry got=%0d want=0", ncarry); end
    total++; if (cnt !== W'(9999) || carry !== 1'b1) begin bad++; $display("FAIL default_top cnt=%0d carry=%0b want 9999 1", cnt, carry); end
    cyc();
    total++; if (cnt !== '0) begin bad++; $display("FAIL default_wrap got=%0d want=0", cnt); end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_center();
    test_load();
    test_bounds();
    test_enable();
    test_syn_load();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
